// File: rtl/fetch_inst_queue.sv
// In-order fetch->decode instruction queue: drops fetch bubbles, stalls fetch one entry early, flushes in one cycle.
// Optional FETCHQ_BYPASS_EN: when the queue is empty and decode is ready, fetch feeds decode in the same cycle.
module fetch_inst_queue #(
   parameter int                DEPTH     = 4,
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   NOP_INSTR = 32'h00000033
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fe_valid,
   input  logic [XLEN-1:0]           fe_pc,
   input  logic [XLEN-1:0]           fe_instr,
   input  logic                      fe_misaligned,
   output logic                      fe_stall,
   input  logic                      flush,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [XLEN-1:0]           dec_pc,
   output logic [XLEN-1:0]           dec_instr,
   output logic                      dec_misaligned,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] HI_WTR = CW'(DEPTH - 1);

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [XLEN-1:0] mem_instr [DEPTH];
   logic            mem_mis   [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fe_stall_q, fe_stall_d;
   logic          overflow_err_q, overflow_err_d;

   logic fe_take, stor_valid, full, byp, push, pop, overflow;

   always_comb begin
      fe_take    = fe_valid & ~flush & (fe_instr != NOP_INSTR);
      stor_valid = (count_q != '0);
      full       = (count_q == FULL);
`ifdef FETCHQ_BYPASS_EN
      byp        = fe_take & dec_ready & ~stor_valid;
`else
      byp        = 1'b0;
`endif
      // Storage pop only; a bypassed entry never touches the buffer.
      pop        = stor_valid & dec_ready & ~flush;
      push       = fe_take & ~byp & (~full | pop);
      overflow   = fe_take & full & ~pop;
   end

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      overflow_err_d = overflow_err_q | overflow;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      // Registered so fetch sees a clean level; the one-entry margin absorbs an in-flight response.
      fe_stall_d = (count_d >= HI_WTR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         fe_stall_q     <= 1'b0;
         overflow_err_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         fe_stall_q     <= fe_stall_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]    <= fe_pc;
         mem_instr[wr_ptr_q] <= fe_instr;
         mem_mis[wr_ptr_q]   <= fe_misaligned;
      end
   end

   // A correct fetch honours fe_stall, so the queue can never overflow.
   always_ff @(posedge clk) begin
      if (!rst) assert (!overflow_err_q);
   end

   always_comb begin
      dec_valid      = stor_valid | byp;
      dec_pc         = '0;
      dec_instr      = NOP_INSTR;
      dec_misaligned = 1'b0;
      if (stor_valid) begin
         dec_pc         = mem_pc[rd_ptr_q];
         dec_instr      = mem_instr[rd_ptr_q];
         dec_misaligned = mem_mis[rd_ptr_q];
      end else if (byp) begin
         dec_pc         = fe_pc;
         dec_instr      = fe_instr;
         dec_misaligned = fe_misaligned;
      end
   end

   assign fe_stall = fe_stall_q;
   assign count    = count_q;
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Small in-order instruction queue between the frontend fetch stage and the decode stage.
- Captures each {pc, instruction, misaligned flag} that fetch delivers and filters out fetch bubbles (NOP fill 32'h00000033).
- Presents entries to decode with a valid/ready handshake.
- Back-pressures fetch early enough to absorb the one L1.5 request that may already be in flight, and supports a single-cycle flush on redirect or exception.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
XLEN, 32, PC and instruction width
NOP_INSTR, 32'h00000033, encoding fetch drives as a bubble; never enqueued

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
fe_valid  input  1  fetch presents a response this cycle (resp fired)
fe_pc  input  XLEN  PC of the presented instruction (pc2)
fe_instr  input  XLEN  byte-swapped instruction (instr2)
fe_misaligned  input  1  instruction-address-misaligned flag for fe_pc
fe_stall  output  1  back-pressure to fetch; holds PC and suppresses new requests
flush  input  1  redirect/exception kill; discards all entries and the same-cycle input
dec_valid  output  1  head entry valid
dec_ready  input  1  decode accepts head this cycle
dec_pc  output  XLEN  head PC
dec_instr  output  XLEN  head instruction; NOP_INSTR when dec_valid=0
dec_misaligned  output  1  head misaligned flag
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register (no pointer-MSB trick).
- Reset (async, rst=1): wr_ptr=rd_ptr=0; count=0; dec_valid=0; dec_instr=NOP_INSTR; dec_pc=0; dec_misaligned=0; fe_stall=0.
- push = fe_valid & ~flush & (fe_instr != NOP_INSTR) & (count != DEPTH, or pop in the same cycle).
- pop = dec_valid & dec_ready & ~flush.
- First-word-fall-through:
  - dec_* are the combinational head of storage; dec_valid = (count != 0).
  - Latency fetch->decode is 1 cycle: an entry written at edge N is visible after edge N.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at count=DEPTH and at count=1; at count=1 the new entry becomes head next cycle.
- fe_stall = (count >= DEPTH-1) registered from next-state count, so it is glitch-free toward fetch.
  - The one-entry margin covers a response already in flight when stall rises.
- Overflow:
  - Push at count=DEPTH without a pop is dropped.
  - A sticky overflow_err internal flag is set; a simulation assertion fires. This cannot occur with a correct fetch.
- Pop on empty is ignored; count never goes below 0.
- Flush:
  - At the next edge, count=0, rd_ptr=wr_ptr=0, and fe_stall=0.
  - fe_valid in the flush cycle is discarded.
  - dec_valid drops the cycle after flush and is never asserted during the flush cycle's handshake (pop suppressed).
  - Flush has priority over push and pop.
- Reset mid-operation: all entries lost immediately (async); no partial state survives.
- A misaligned entry is queued like any other; decode owns the trap.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined:
  - When count=0 and fe_valid & dec_ready & ~flush and fe_instr != NOP_INSTR, fe_* pass straight to dec_* the same cycle with dec_valid=1, and nothing is written.
  - When count=0 and dec_ready=0, the entry is written normally.
  - Fetch-to-decode latency becomes 0 when empty.
- Not defined:
  - Always 1-cycle latency; dec_* driven only from storage.

Test Plan:
- Reset: assert rst mid-cycle with count=3 -> immediately count=0, dec_valid=0, dec_instr=32'h00000033, fe_stall=0.
- Stream: fe_valid with pc 0x40000000, 0x40000004, 0x40000008, dec_ready=1 -> dec_pc sequence 0x40000000/04/08, each one cycle after input (same cycle with FETCHQ_BYPASS_EN); count stays <=1.
- Bubble filter: fe_valid with fe_instr=32'h00000033 between two real instructions -> only 2 entries enqueued; count never counts the bubble.
- Back-pressure with DEPTH=4 and dec_ready=0:
  - Push 3 entries -> fe_stall=1 after third edge.
  - Fourth in-flight push accepted, count=4.
  - Fifth push with no pop -> dropped, overflow_err=1.
  - With dec_ready=1 and fe_valid at count=4 -> count stays 4, order preserved across pointer wrap.
- Flush: count=3, flush=1 together with fe_valid (pc 0x40000010) -> next cycle count=0, dec_valid=0; no pop recorded; pc 0x40000010 never appears at dec_pc.
- Misaligned: fe_pc=0x40000002, fe_misaligned=1 -> dec_misaligned=1 with dec_pc=0x40000002; following aligned entry shows dec_misaligned=0.
